// File: rtl/distribute_cmd_issuer.sv
// distribute_cmd_issuer: sequential front-end for the combinational distribute switch.
// A config handshake programs a route command and beat count. In RUN, the block
// registers each accepted beat, with lane valids taken from the command, and pulses
// o_done on the final beat.
// Optional build macro DIST_CMD_ISSUER_CFG_QUEUE_EN adds a one-entry shadow config,
// so consecutive programs run back-to-back.
module distribute_cmd_issuer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_cfg_valid,
    input  logic [1:0]            i_cfg_cmd,
    input  logic [CNT_WIDTH-1:0]  i_cfg_len,
    output logic                  o_cfg_ready,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data_bus,
    output logic                  o_ready,
    output logic [1:0]            o_valid,
    output logic [DATA_WIDTH-1:0] o_data_bus,
    output logic                  o_en,
    output logic [1:0]            o_cmd,
    output logic                  o_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [1:0]           cmd_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 cfg_fire;
    logic                 beat_fire;
    logic                 last_beat;

    assign o_ready   = (state == RUN);
    assign cfg_fire  = i_cfg_valid && o_cfg_ready;
    assign beat_fire = i_valid && o_ready;
    assign last_beat = beat_fire && (cnt_r == CNT_WIDTH'(1));
    assign o_cmd     = cmd_r;

`ifdef DIST_CMD_ISSUER_CFG_QUEUE_EN
    logic                 sh_full;
    logic [1:0]           sh_cmd;
    logic [CNT_WIDTH-1:0] sh_len;
    logic                 zero_pend;

    assign o_cfg_ready = !sh_full;
`else
    assign o_cfg_ready = (state == IDLE);
`endif

    // Program FSM, beat counter and registered switch-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_r      <= 2'b00;
            cnt_r      <= '0;
            o_valid    <= 2'b00;
            o_data_bus <= '0;
            o_en       <= 1'b0;
            o_done     <= 1'b0;
`ifdef DIST_CMD_ISSUER_CFG_QUEUE_EN
            sh_full    <= 1'b0;
            sh_cmd     <= 2'b00;
            sh_len     <= '0;
            zero_pend  <= 1'b0;
`endif
        end else begin
            // Idle cycles present dummy zero data to the switch
            o_valid    <= 2'b00;
            o_data_bus <= '0;
            o_en       <= 1'b0;
            o_done     <= 1'b0;
`ifdef DIST_CMD_ISSUER_CFG_QUEUE_EN
            zero_pend  <= 1'b0;
            if (zero_pend) begin
                o_done <= 1'b1;
            end
`endif
            if (beat_fire) begin
                o_en       <= 1'b1;
                o_valid    <= {cmd_r[1], cmd_r[0]};
                // NA drains the stream: the beat is consumed but not delivered
                o_data_bus <= (cmd_r == 2'b00) ? '0 : i_data_bus;
                cnt_r      <= cnt_r - CNT_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        if (i_cfg_len != '0) begin
                            cmd_r <= i_cfg_cmd;
                            cnt_r <= i_cfg_len;
                            state <= RUN;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
`ifdef DIST_CMD_ISSUER_CFG_QUEUE_EN
                    if (cfg_fire && !last_beat) begin
                        sh_full <= 1'b1;
                        sh_cmd  <= i_cfg_cmd;
                        sh_len  <= i_cfg_len;
                    end
                    if (last_beat) begin
                        o_done <= 1'b1;
                        // The next program comes from the shadow, or directly from a config
                        // that lands on the last beat. A zero-length one only reports done,
                        // one cycle after this program's done.
                        if (sh_full) begin
                            sh_full <= 1'b0;
                            if (sh_len != '0) begin
                                cmd_r <= sh_cmd;
                                cnt_r <= sh_len;
                            end else begin
                                state     <= IDLE;
                                zero_pend <= 1'b1;
                            end
                        end else if (cfg_fire) begin
                            if (i_cfg_len != '0) begin
                                cmd_r <= i_cfg_cmd;
                                cnt_r <= i_cfg_len;
                            end else begin
                                state     <= IDLE;
                                zero_pend <= 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
`else
                    if (last_beat) begin
                        o_done <= 1'b1;
                        state  <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_distribute_cmd_issuer.sv
// Scoreboard bench for distribute_cmd_issuer: directed programs push the expected
// switch-side outputs into a queue; a negedge monitor pops and compares them.
module tb_distribute_cmd_issuer;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_cfg_valid;
    logic [1:0]    i_cfg_cmd;
    logic [CW-1:0] i_cfg_len;
    logic          o_cfg_ready;
    logic          i_valid;
    logic [DW-1:0] i_data_bus;
    logic          o_ready;
    logic [1:0]    o_valid;
    logic [DW-1:0] o_data_bus;
    logic          o_en;
    logic [1:0]    o_cmd;
    logic          o_done;

    typedef struct packed {
        logic [1:0]    valid;
        logic [DW-1:0] data;
        logic [1:0]    cmd;
        logic          en;
        logic          done;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;
    logic mon_en = 1'b0;

    distribute_cmd_issuer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_valid(i_cfg_valid), .i_cfg_cmd(i_cfg_cmd), .i_cfg_len(i_cfg_len),
        .o_cfg_ready(o_cfg_ready),
        .i_valid(i_valid), .i_data_bus(i_data_bus), .o_ready(o_ready),
        .o_valid(o_valid), .o_data_bus(o_data_bus), .o_en(o_en),
        .o_cmd(o_cmd), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Monitor: every output presentation pops one expectation; otherwise outputs must be dummy zeros
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_en || o_done) begin
                tests++;
                if (q.size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_out: got valid=%b data=%h cmd=%b en=%b done=%b, required no output",
                             o_valid, o_data_bus, o_cmd, o_en, o_done);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (o_valid !== e.valid || o_data_bus !== e.data || o_cmd !== e.cmd ||
                        o_en !== e.en || o_done !== e.done) begin
                        failed++;
                        $display("FAIL beat_out: got valid=%b data=%h cmd=%b en=%b done=%b, required valid=%b data=%h cmd=%b en=%b done=%b",
                                 o_valid, o_data_bus, o_cmd, o_en, o_done,
                                 e.valid, e.data, e.cmd, e.en, e.done);
                    end
                end
            end else begin
                tests++;
                if (o_valid !== 2'b00 || o_data_bus !== '0) begin
                    failed++;
                    $display("FAIL gap_out: got valid=%b data=%h, required valid=00 data=0",
                             o_valid, o_data_bus);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] v, input logic [DW-1:0] d, input logic [1:0] c,
                        input logic en, input logic dn);
        exp_t e;
        e.valid = v; e.data = d; e.cmd = c; e.en = en; e.done = dn;
        q.push_back(e);
    endtask

    // One config handshake; waits (bounded) for o_cfg_ready
    task automatic cfg(input logic [1:0] c, input logic [CW-1:0] len);
        int n;
        n = 0;
        i_cfg_valid = 1'b1;
        i_cfg_cmd   = c;
        i_cfg_len   = len;
        while (!o_cfg_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("cfg_ready_timeout", 64'd0, 64'd1);
        step();
        i_cfg_valid = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [1:0] v, input logic [DW-1:0] ed,
                        input logic [1:0] c, input logic dn);
        i_valid    = 1'b1;
        i_data_bus = d;
        push(v, ed, c, 1'b1, dn);
        step();
        i_valid    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        // Reset with random inputs
        repeat (3) begin
            i_cfg_valid = 1'($urandom);
            i_cfg_cmd   = 2'($urandom);
            i_cfg_len   = CW'($urandom);
            i_valid     = 1'($urandom);
            i_data_bus  = $urandom;
            step();
        end
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data", 64'(o_data_bus), 64'd0);
        chk("rst_en", 64'(o_en), 64'd0);
        chk("rst_cmd", 64'(o_cmd), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_cfg_ready", 64'(o_cfg_ready), 64'd1);
        chk("rst_ready", 64'(o_ready), 64'd0);
        rst_n = 1'b1;
        i_cfg_valid = 1'b0; i_cfg_cmd = 2'b00; i_cfg_len = '0;
        i_valid = 1'b0; i_data_bus = '0;
        mon_en = 1'b1;
        step();

        // Duplicate, 4 back-to-back beats
        cfg(2'b11, 8'd4);
        chk("run_ready", 64'(o_ready), 64'd1);
        for (int unsigned k = 0; k < 4; k++)
            beat(32'hA0 + k, 2'b11, 32'hA0 + k, 2'b11, (k == 3));
        chk("idle_after_prog", 64'(o_ready), 64'd0);
        step();

        // Branch_low with gaps
        cfg(2'b01, 8'd3);
        beat(32'hB0, 2'b01, 32'hB0, 2'b01, 1'b0);
        step();
        beat(32'hB1, 2'b01, 32'hB1, 2'b01, 1'b0);
        step();
        beat(32'hB2, 2'b01, 32'hB2, 2'b01, 1'b1);
        // Beat offered in IDLE is not consumed
        i_valid = 1'b1; i_data_bus = 32'hDEAD;
        step();
        i_valid = 1'b0;
        step();

        // NA drains, then zero-length program
        cfg(2'b00, 8'd2);
        beat(32'hC0, 2'b00, 32'h0, 2'b00, 1'b0);
        beat(32'hC1, 2'b00, 32'h0, 2'b00, 1'b1);
        step();
        push(2'b00, 32'h0, 2'b00, 1'b0, 1'b1);
        cfg(2'b00, 8'd0);
        chk("len0_no_run", 64'(o_ready), 64'd0);
        step();

        // Branch_high aborted by reset; config and beat offered together in IDLE
        i_valid = 1'b1; i_data_bus = 32'hEE;
        cfg(2'b10, 8'd5);
        i_valid = 1'b0;
        beat(32'hD0, 2'b10, 32'hD0, 2'b10, 1'b0);
        beat(32'hD1, 2'b10, 32'hD1, 2'b10, 1'b0);
        rst_n = 1'b0; i_valid = 1'b1; i_data_bus = 32'hD2;
        step();
        rst_n = 1'b1; i_valid = 1'b0;
        chk("abort_en", 64'(o_en), 64'd0);
        chk("abort_valid", 64'(o_valid), 64'd0);
        chk("abort_cmd", 64'(o_cmd), 64'd0);
        chk("abort_done", 64'(o_done), 64'd0);
        chk("abort_ready", 64'(o_ready), 64'd0);
        step();
        cfg(2'b01, 8'd2);
        beat(32'hE0, 2'b01, 32'hE0, 2'b01, 1'b0);
        beat(32'hE1, 2'b01, 32'hE1, 2'b01, 1'b1);
        step();

        // Second config offered during RUN, continuous beats
        cfg(2'b10, 8'd2);
        i_valid = 1'b1;
        i_cfg_valid = 1'b1; i_cfg_cmd = 2'b01; i_cfg_len = 8'd2;
`ifdef DIST_CMD_ISSUER_CFG_QUEUE_EN
        chk("shadow_ready", 64'(o_cfg_ready), 64'd1);
        i_data_bus = 32'hF0; push(2'b10, 32'hF0, 2'b10, 1'b1, 1'b0);
        step();
        i_cfg_valid = 1'b0;
        chk("shadow_full", 64'(o_cfg_ready), 64'd0);
        // o_cmd follows cmd_r, which switches to the queued program at this edge
        i_data_bus = 32'hF1; push(2'b10, 32'hF1, 2'b01, 1'b1, 1'b1);
        step();
        chk("no_bubble", 64'(o_ready), 64'd1);
        i_data_bus = 32'hF2; push(2'b01, 32'hF2, 2'b01, 1'b1, 1'b0);
        step();
        i_data_bus = 32'hF3; push(2'b01, 32'hF3, 2'b01, 1'b1, 1'b1);
        step();
`else
        chk("held_off_0", 64'(o_cfg_ready), 64'd0);
        i_data_bus = 32'hF0; push(2'b10, 32'hF0, 2'b10, 1'b1, 1'b0);
        step();
        chk("held_off_1", 64'(o_cfg_ready), 64'd0);
        i_data_bus = 32'hF1; push(2'b10, 32'hF1, 2'b10, 1'b1, 1'b1);
        step();
        chk("idle_cfg_ready", 64'(o_cfg_ready), 64'd1);
        i_data_bus = 32'hEF;
        step();
        i_cfg_valid = 1'b0;
        chk("bubble", 64'(o_en), 64'd0);
        i_data_bus = 32'hF2; push(2'b01, 32'hF2, 2'b01, 1'b1, 1'b0);
        step();
        i_data_bus = 32'hF3; push(2'b01, 32'hF3, 2'b01, 1'b1, 1'b1);
        step();
`endif
        i_valid = 1'b0;
        repeat (4) step();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
